inverting_encoder: RTL and testbench

Receive-side counterpart of the 4-to-16 active-low layer/panel select decoder. Watches 16 active-low select lines, y_n, arriving from another board or from the cube's layer-select bus. Synchronizes them, requires them to be stable, and classifies them. It then reports the 4-bit address of the single asserted line, or flags that no line or several lines are asserted. It is used to check the decoder's output in-system and to recover the current layer address on a downstream board.

---
 rtl/inverting_encoder.sv | 121 ++++++++++++
 tb/tb_inverting_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverting_encoder.sv
// Receive-side checker for the 16-line active-low layer select bus: synchronizes y_n,
// waits for a stable run of samples, then reports the single asserted line or a none/multi condition.
module inverting_encoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] y_n,
  input  logic        enable,
  output logic [3:0]  addr,
  output logic        valid,
  output logic        none,
  output logic        multi_err,
  output logic        changed
);

  typedef enum logic [1:0] {
    SETTLING = 2'd0,
    LOCKED   = 2'd1,
    IDLE     = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_t      state;
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] s;
  logic [15:0] p;
  logic [3:0]  r;
  logic [3:0]  r_next;
  logic [4:0]  zero_cnt;
  logic [3:0]  one_idx;
  logic        s_changed;
  logic        stable_hit;
  logic        was_locked;

  // Inactive value is all ones, so reset loads 16'hFFFF into every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 16'hFFFF;
    end else begin
      sync_q[0] <= y_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign s_changed = (s != p);

  // r_next is the run length including the current sample, so a decision can be
  // taken on the very edge the run reaches STABLE.
  always_comb begin
    r_next = r;
    if (s_changed)        r_next = 4'd1;
    else if (r != STABLE) r_next = r + 4'd1;
  end

  assign stable_hit = enable && (r_next == STABLE);

  always_comb begin
    zero_cnt = '0;
    one_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (!s[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        one_idx  = 4'(i);
      end
    end
  end

  // addr doubles as the last locked address used to suppress repeat changed pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SETTLING;
      p          <= 16'hFFFF;
      r          <= '0;
      addr       <= '0;
      changed    <= 1'b0;
      was_locked <= 1'b0;
    end else begin
      p       <= s;
      changed <= 1'b0;
      if (!enable) begin
        r          <= '0;
        state      <= SETTLING;
        was_locked <= 1'b0;
      end else begin
        r <= r_next;
        case (state)
          SETTLING: begin
            if (stable_hit) begin
              if (zero_cnt == 5'd0) begin
                state      <= IDLE;
                was_locked <= 1'b0;
              end else if (zero_cnt == 5'd1) begin
                state      <= LOCKED;
                addr       <= one_idx;
                changed    <= !was_locked || (addr != one_idx);
                was_locked <= 1'b1;
              end else begin
                state      <= FAULT;
                was_locked <= 1'b0;
              end
            end
          end
          LOCKED, IDLE, FAULT: begin
            if (s_changed) state <= SETTLING;
          end
          default: state <= SETTLING;
        endcase
      end
    end
  end

  assign valid     = (state == LOCKED);
  assign none      = (state == IDLE);
  assign multi_err = (state == FAULT);

endmodule

// File: tb/tb_inverting_encoder.sv
// Bench for inverting_encoder: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a flag-level behavioural model.
module tb_inverting_encoder;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] y_n = 16'hFFFF;
  logic        enable = 1'b1;
  logic [3:0]  addr;
  logic        valid;
  logic        none;
  logic        multi_err;
  logic        changed;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  inverting_encoder #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .reset(reset), .y_n(y_n), .enable(enable),
    .addr(addr), .valid(valid), .none(none), .multi_err(multi_err), .changed(changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pipe[$];
  logic [15:0] m_prev;
  int          m_run;
  logic [3:0]  m_addr;
  logic        m_valid, m_none, m_multi, m_changed, m_was_locked;
  logic [7:0]  exp_q[$];

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(16'hFFFF);
    m_prev = 16'hFFFF;
    m_run = 0;
    m_addr = 4'd0;
    m_valid = 1'b0; m_none = 1'b0; m_multi = 1'b0; m_changed = 1'b0;
    m_was_locked = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [15:0] s_pre;
    logic [15:0] lo;
    logic        chg;
    int          nz;
    int          a;
    s_pre = m_pipe[0];
    chg = (s_pre != m_prev);
    m_changed = 1'b0;
    if (!enable) begin
      m_run = 0;
      m_valid = 1'b0; m_none = 1'b0; m_multi = 1'b0;
      m_was_locked = 1'b0;
    end else begin
      m_run = chg ? 1 : m_run + 1;
      if (m_valid || m_none || m_multi) begin
        if (chg) begin
          m_valid = 1'b0; m_none = 1'b0; m_multi = 1'b0;
        end
      end else if (m_run >= STABLE) begin
        lo = ~s_pre;
        nz = $countones(lo);
        if (nz == 0) begin
          m_none = 1'b1;
          m_was_locked = 1'b0;
        end else if (nz == 1) begin
          a = 0;
          for (int k = 0; k < 16; k++) if (lo == (16'h1 << k)) a = k;
          m_changed = !m_was_locked || (4'(a) != m_addr);
          m_addr = 4'(a);
          m_valid = 1'b1;
          m_was_locked = 1'b1;
        end else begin
          m_multi = 1'b1;
          m_was_locked = 1'b0;
        end
      end
    end
    m_prev = s_pre;
    m_pipe.push_back(y_n);
    void'(m_pipe.pop_front());
    exp_q.push_back({m_addr, m_valid, m_none, m_multi, m_changed});
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs_vs_model", 32'({addr, valid, none, multi_err, changed}), 32'(e));
      check("flags_exclusive", 32'($countones({valid, none, multi_err}) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          chg_cnt;
    int          bad_cnt;
    int          drop_cnt;
    int          found;
    int          lat;
    int          kind;
    int          a;
    int          b;
    logic [15:0] v;
    logic [15:0] prev_v;

    model_reset();
    reset = 1'b1; y_n = 16'hFFFF; enable = 1'b1;
    cyc(3);
    check("reset_outputs", 32'({addr, valid, none, multi_err, changed}), 32'd0);

    // 1: idle bus qualifies as none
    reset = 1'b0;
    for (int j = 1; j <= SYNC + STABLE; j++) begin
      @(negedge clk);
      if (j == 3) check("settling_zero", 32'({valid, none, multi_err, changed}), 32'd0);
    end
    check("idle_none", 32'({valid, none, multi_err}), 32'b010);

    // 2: one-hot sweep
    for (int i = 0; i < 16; i++) begin
      y_n = ~(16'h1 << i);
      chg_cnt = 0;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        chg_cnt += int'(changed);
        if (j == 5) check("sweep_not_yet", 32'(valid), 32'd0);
        if (j == 6) check($sformatf("sweep_lock_%0d", i),
                          32'({valid, none, multi_err, addr}), 32'({3'b100, 4'(i)}));
      end
      check($sformatf("sweep_changed_%0d", i), 32'(chg_cnt), 32'd1);
    end

    // 3: two lines -> fault, then single line -> lock
    y_n = 16'hFFF5;
    chg_cnt = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chg_cnt += int'(changed);
      if (j == 6) check("multi_fault", 32'({valid, none, multi_err}), 32'b001);
    end
    check("multi_no_changed", 32'(chg_cnt), 32'd0);
    y_n = 16'hFFF7;
    chg_cnt = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chg_cnt += int'(changed);
      if (j == 6) check("after_fault_lock3", 32'({valid, addr}), 32'({1'b1, 4'd3}));
    end
    check("after_fault_changed", 32'(chg_cnt), 32'd1);

    // 4: short glitch on addr 5
    y_n = 16'hFFDF;
    cyc(10);
    check("glitch_pre_lock5", 32'({valid, addr}), 32'({1'b1, 4'd5}));
    y_n = 16'hFFDE;
    chg_cnt = 0; bad_cnt = 0; drop_cnt = 0;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j == 2) y_n = 16'hFFDF;
      chg_cnt += int'(changed);
      bad_cnt += int'((valid && addr == 4'd0) || multi_err);
      drop_cnt += int'(!valid);
    end
    check("glitch_no_bad", 32'(bad_cnt), 32'd0);
    check("glitch_no_changed", 32'(chg_cnt), 32'd0);
    check("glitch_dropped", 32'(drop_cnt > 0), 32'd1);
    check("glitch_relock5", 32'({valid, addr}), 32'({1'b1, 4'd5}));

    // 5: enable drop on addr 9
    y_n = ~(16'h1 << 9);
    cyc(10);
    enable = 1'b0;
    @(negedge clk);
    check("enable_off_drop", 32'(valid), 32'd0);
    cyc(2);
    enable = 1'b1;
    for (int j = 1; j <= STABLE; j++) begin
      @(negedge clk);
      if (j == STABLE - 1) check("enable_requalify_wait", 32'(valid), 32'd0);
    end
    check("enable_relock9", 32'({valid, changed, addr}), 32'({2'b11, 4'd9}));

    // 6: asynchronous reset while locked on addr 12
    y_n = ~(16'h1 << 12);
    cyc(10);
    check("pre_reset_lock12", 32'({valid, addr}), 32'({1'b1, 4'd12}));
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", 32'({addr, valid, none, multi_err, changed}), 32'd0);
    cyc(2);
    reset = 1'b0;
    found = 0; lat = 0;
    for (int j = 1; j <= 10 && found == 0; j++) begin
      @(negedge clk);
      lat = j;
      if (valid) found = 1;
    end
    check("reset_relock_seen", 32'(found), 32'd1);
    check("reset_relock_latency", 32'(lat), 32'd6);
    check("reset_relock12", 32'({valid, changed, addr}), 32'({2'b11, 4'd12}));

    // random run against the model
    prev_v = y_n;
    for (int seg = 0; seg < 250; seg++) begin
      kind = int'($urandom_range(0, 11));
      if (kind < 6) v = ~(16'h1 << $urandom_range(0, 15));
      else if (kind < 8) v = 16'hFFFF;
      else if (kind < 10) begin
        a = int'($urandom_range(0, 15));
        b = (a + 1 + int'($urandom_range(0, 14))) % 16;
        v = ~((16'h1 << a) | (16'h1 << b));
      end else v = prev_v;
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        cyc(int'($urandom_range(1, 3)));
        enable = 1'b1;
      end
      y_n = v;
      cyc(int'($urandom_range(1, 9)));
      if ($urandom_range(0, 4) == 0) begin
        y_n = prev_v;
        cyc(int'($urandom_range(1, 3)));
        y_n = v;
        cyc(int'($urandom_range(1, 8)));
      end
      prev_v = v;
    end
    cyc(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
